// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Iterative Booth multiplier with one shared add/shift datapath. Each request
// produces a 2*WIDTH-bit product after a fixed number of cycles. A runtime
// signed_mode input selects two's-complement or unsigned operands.
// The start/busy/done handshake works as follows:
//   - start is sampled only in IDLE.
//   - busy is high during RUN.
//   - done is a one-cycle pulse that comes with the product update.
// Build option: define BOOTH_RADIX4_EN to select the radix-4 datapath, which
// performs two Booth bits per step. Leave it undefined for radix-2.
// WIDTH must be even and >= 4.

module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Every operand is handled as a signed N-bit value. The two extra bits
    // let an unsigned operand stay positive after extension.
    localparam int N = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = N / 2;
`else
    localparam int ITER = N;
`endif
    localparam int             CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N-1:0]       r_m;        // multiplicand
    logic [N+1:0]       r_p;        // accumulator, signed, two guard bits for +-2M
    logic [N-1:0]       r_q;        // multiplier, shifts out as the product low half
    logic               r_q1;       // Booth history bit
    logic [CW-1:0]      r_cnt;      // completed Booth steps
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_step;
    logic               w_latch;
    logic [N-1:0]       w_a_ext;
    logic [N-1:0]       w_b_ext;
    logic [N+1:0]       w_m_ext;
    logic [N+1:0]       w_m_neg;
    logic [N+1:0]       w_addend;
    logic [N+1:0]       w_sum;
    logic [N+1:0]       w_p_next;
    logic [N-1:0]       w_q_next;
    logic               w_q1_next;

    // Operand extension: sign-extend in signed mode, zero-extend otherwise.
    assign w_a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign w_b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    // +M and -M at accumulator width.
    assign w_m_ext = {{2{r_m[N-1]}}, r_m};
    assign w_m_neg = ~w_m_ext + {{(N+1){1'b0}}, 1'b1};

`ifdef BOOTH_RADIX4_EN
    logic [N+1:0] w_m2;
    logic [N+1:0] w_m2_neg;

    // +2M is M shifted left by one and sign-extended to accumulator width.
    assign w_m2     = {r_m[N-1], r_m, 1'b0};
    assign w_m2_neg = ~w_m2 + {{(N+1){1'b0}}, 1'b1};

    // Radix-4 step: recode {Q[1],Q[0],q_1} into 0/+-M/+-2M, add, then shift by two.
    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_q1})
            3'b001, 3'b010: w_addend = w_m_ext;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = w_m2_neg;
            3'b101, 3'b110: w_addend = w_m_neg;
            default:        w_addend = '0;
        endcase
        w_sum     = r_p + w_addend;
        w_p_next  = {{2{w_sum[N+1]}}, w_sum[N+1:2]};
        w_q_next  = {w_sum[1:0], r_q[N-1:2]};
        w_q1_next = r_q[1];
    end
`else
    // Radix-2 step: recode {Q[0],q_1} into 0/+-M, add, then shift by one.
    always_comb begin
        w_addend = '0;
        case ({r_q[0], r_q1})
            2'b01:   w_addend = w_m_ext;
            2'b10:   w_addend = w_m_neg;
            default: w_addend = '0;
        endcase
        w_sum     = r_p + w_addend;
        w_p_next  = {w_sum[N+1], w_sum[N+1:1]};
        w_q_next  = {w_sum[0], r_q[N-1:1]};
        w_q1_next = r_q[0];
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: accept in IDLE, leave RUN after the last step,
    // and spend one cycle in DONE to publish the result.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and datapath control strobes.
    always_comb begin
        busy    = 1'b0;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE:  w_load  = start;
            S_RUN:   begin busy = 1'b1; w_step = 1'b1; end
            S_DONE:  w_latch = 1'b1;
            default: ;
        endcase
    end

    // Booth datapath: load the operands on accept, then run one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_p   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_m   <= w_a_ext;
            r_p   <= '0;
            r_q   <= w_b_ext;
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_p   <= w_p_next;
            r_q   <= w_q_next;
            r_q1  <= w_q1_next;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Result register. The product is the low 2*WIDTH bits of {P,Q}. It is
    // captured when leaving DONE and held until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= w_latch;
            if (w_latch) begin
                r_product <= {r_p[WIDTH-3:0], r_q};
            end
        end
    end

    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Testbench for booth_multiplier_seq (WIDTH=32). Expected products come from a
// plain widened multiply. They are queued at stimulus time and then popped
// and compared whenever done pulses.
`timescale 1ns/1ps

module tb_booth_multiplier_seq;

    localparam int WIDTH = 32;
    localparam int N     = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER  = N / 2;
`else
    localparam int ITER  = N;
`endif
    localparam int PERIOD = ITER + 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*WIDTH-1:0] exp_q[$];

    booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: widen both operands according to the mode, then multiply.
    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic sm);
        logic [2*WIDTH-1:0] ex;
        logic [2*WIDTH-1:0] ey;
        ex = sm ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ey = sm ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return ex * ey;
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        logic [WIDTH-1:0] v;
        case ($urandom % 8)
            0:       v = '0;
            1:       v = WIDTH'(1);
            2:       v = '1;
            3:       v = {1'b1, {(WIDTH-1){1'b0}}};
            4:       v = {1'b0, {(WIDTH-1){1'b1}}};
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done product=%h required=no done", product);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (product !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard product=%h required=%h", product, e);
                end else begin
                    $display("op ok product=%h", product);
                end
            end
        end
    end

    // One full transaction with latency, busy-width and hold checks.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic sm, input string name);
        int d;
        int busy_cyc;
        logic seen;
        logic [2*WIDTH-1:0] e;
        @(negedge clk);
        a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
        e = ref_mul(ta, tb_v, sm);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = 1'($urandom);
        d = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && d < ITER + 20) begin
            if (busy) busy_cyc++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                d++;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s timeout got=no done within %0d cycles required=done", name, ITER + 20);
        end else begin
            n_checks++;
            if (d != ITER + 1) begin
                n_errors++;
                $display("FAIL %s latency got=%0d required=%0d", name, d, ITER + 1);
            end
            n_checks++;
            if (busy_cyc != ITER) begin
                n_errors++;
                $display("FAIL %s busy_cycles got=%0d required=%0d", name, busy_cyc, ITER);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s done_width got=%b required=0", name, done);
            end
            n_checks++;
            if (product !== e) begin
                n_errors++;
                $display("FAIL %s product_hold got=%h required=%h", name, product, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            n_errors++;
            $display("FAIL reset_state got=busy %b done %b product %h required=0 0 0", busy, done, product);
        end
        // A start while reset is held must not be accepted.
        start = 1'b1; a = 32'h5; b = 32'h6;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_beats_start busy=%b required=0", busy);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset busy=%b required=0", busy);
        end
        $display("reset checks done");
    endtask

    task automatic test_directed();
        run_op(32'hFFFFFFF9, 32'h00000003, 1'b1, "signed_m7x3");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "unsigned_max");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "signed_m1xm1");
        run_op(32'h80000000, 32'h80000000, 1'b1, "signed_minxmin");
        run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, "signed_minxmax");
        run_op(32'h00000000, 32'h12345678, 1'b1, "zero_x");
        run_op(32'h00000001, 32'h87654321, 1'b0, "one_x_unsigned");
        run_op(32'hFFFFFFFF, 32'h00001234, 1'b1, "neg1_x");
        run_op(32'h80000000, 32'h80000000, 1'b0, "unsigned_msb");
    endtask

    task automatic test_back_to_back();
        int prev_done;
        int ndone;
        logic [2*WIDTH-1:0] last;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rs;
        prev_done = -1; ndone = 0; last = '0;
        for (int c = 0; c <= 3 * PERIOD + 5; c++) begin
            @(negedge clk);
            if (done) begin
                if (ndone > 0) begin
                    n_checks++;
                    if (c - prev_done != PERIOD) begin
                        n_errors++;
                        $display("FAIL b2b_spacing got=%0d required=%0d", c - prev_done, PERIOD);
                    end
                end
                prev_done = c; last = product; ndone++;
            end else if (ndone > 0) begin
                n_checks++;
                if (product !== last) begin
                    n_errors++;
                    $display("FAIL b2b_hold got=%h required=%h", product, last);
                end
            end
            if (c < 3 * PERIOD) begin
                ra = pick_operand(); rb = pick_operand(); rs = 1'($urandom);
                a = ra; b = rb; signed_mode = rs; start = 1'b1;
                if (c % PERIOD == 0) exp_q.push_back(ref_mul(ra, rb, rs));
            end else begin
                start = 1'b0;
            end
        end
        n_checks++;
        if (ndone != 3 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_count got=%0d dones %0d pending required=3 dones 0 pending", ndone, exp_q.size());
        end
        $display("back-to-back done count=%0d", ndone);
    endtask

    task automatic test_reset_mid();
        int seen_done;
        @(negedge clk);
        a = 32'h00001111; b = 32'h00002222; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_running busy=%b required=1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            n_errors++;
            $display("FAIL midrst_abort got=busy %b done %b product %h required=0 0 0", busy, done, product);
        end
        seen_done = 0;
        repeat (ITER + 5) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_errors++;
            $display("FAIL midrst_no_done got=%0d required=0", seen_done);
        end
        run_op(32'hFFFFFFF9, 32'h00000003, 1'b1, "after_midrst");
    endtask

    task automatic test_random_sweep();
        for (int i = 0; i < 250; i++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom), "random");
        end
    endtask

    // Watchdog bounding the whole run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random_sweep();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_results got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
